// File: rtl/alu_slice_exec_if.sv
// Request/response bundle for the bit-sliced ALU.
// The master side issues operations and consumes results.
// The slave side is the execution unit.
interface alu_slice_exec_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       alu_control;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             illegal;

  modport master (
    output in_valid,
    output alu_control,
    output src_a,
    output src_b,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  result,
    input  zero,
    input  illegal
  );

  modport slave (
    input  in_valid,
    input  alu_control,
    input  src_a,
    input  src_b,
    input  out_ready,
    output in_ready,
    output out_valid,
    output result,
    output zero,
    output illegal
  );
endinterface

// File: rtl/alu_slice_exec.sv
// Multi-cycle MIPS ALU that works through the operands SLICE bits per cycle.
// The operands are held in shift registers so the active slice is always
// the low SLICE bits. Each partial result enters at the top of an
// accumulator and shifts down, so after NSLICE cycles the accumulator
// holds the whole word in its correct bit order.
module alu_slice_exec #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  alu_slice_exec_if.slave  bus
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  // Captured operation and per-slice working state
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [2:0]       code;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] partial;

  // Registered outputs, held from DONE until the next result is written
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             illegal_q;

  // Request decode
  logic accept;
  logic req_defined;
  logic req_invert;

  // Slice datapath
  logic [SLICE-1:0] a_k;
  logic [SLICE-1:0] b_k;
  logic [SLICE:0]   sum_ext;
  logic [SLICE-1:0] slice_res;
  logic             cout;
  logic             overflow;
  logic             slt_bit;
  logic             last_slice;
  logic [WIDTH-1:0] res_ext;
  logic [WIDTH-1:0] partial_next;
  logic [WIDTH-1:0] final_word;

  // Classify the incoming code and detect an accepted request
  always_comb begin
    accept      = (state == IDLE) && bus.in_valid;
    req_defined = 1'b0;
    req_invert  = 1'b0;
    case (bus.alu_control)
      OP_AND, OP_OR, OP_ADD: req_defined = 1'b1;
      OP_SUB, OP_SLT: begin
        req_defined = 1'b1;
        req_invert  = 1'b1;
      end
      default: begin
        req_defined = 1'b0;
        req_invert  = 1'b0;
      end
    endcase
  end

  // One slice of add/sub/logic, plus the assembled word and the slt decision
  always_comb begin
    a_k     = op_a[SLICE-1:0];
    b_k     = op_b[SLICE-1:0];
    sum_ext = {1'b0, a_k} + {1'b0, b_k} + {{SLICE{1'b0}}, carry};
    case (code)
      OP_AND:  slice_res = a_k & b_k;
      OP_OR:   slice_res = a_k | b_k;
      default: slice_res = sum_ext[SLICE-1:0];
    endcase
    cout = sum_ext[SLICE];

    res_ext              = '0;
    res_ext[SLICE-1:0]   = slice_res;
    partial_next         = (partial >> SLICE) | (res_ext << (WIDTH - SLICE));

    // Signed overflow: operands agree in sign but the sum's sign differs.
    // Only meaningful on the top slice, where the MSBs are the word's MSBs.
    overflow = (a_k[SLICE-1] == b_k[SLICE-1]) && (slice_res[SLICE-1] != a_k[SLICE-1]);
    slt_bit  = slice_res[SLICE-1] ^ overflow;

    if (code == OP_SLT) begin
      final_word = {{(WIDTH-1){1'b0}}, slt_bit};
    end else begin
      final_word = partial_next;
    end

    last_slice = (cnt == CW'(NSLICE - 1));
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = req_defined ? BUSY : DONE;
        end
      end
      BUSY: begin
        if (last_slice) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state
  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
    bus.result    = result_q;
    bus.zero      = zero_q;
    bus.illegal   = illegal_q;
  end

  // Operand capture, slice stepping and result write-back
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      op_a      <= '0;
      op_b      <= '0;
      code      <= '0;
      cnt       <= '0;
      carry     <= 1'b0;
      partial   <= '0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_a    <= bus.src_a;
            op_b    <= req_invert ? ~bus.src_b : bus.src_b;
            code    <= bus.alu_control;
            cnt     <= '0;
            carry   <= req_invert;
            partial <= '0;
            if (!req_defined) begin
              result_q  <= '0;
              zero_q    <= 1'b1;
              illegal_q <= 1'b1;
            end
          end
        end
        BUSY: begin
          op_a    <= op_a >> SLICE;
          op_b    <= op_b >> SLICE;
          partial <= partial_next;
          if ((code != OP_AND) && (code != OP_OR)) begin
            carry <= cout;
          end
          if (last_slice) begin
            cnt       <= '0;
            result_q  <= final_word;
            zero_q    <= (final_word == '0);
            illegal_q <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end
endmodule
